branch_metric_unit: RTL and testbench

Radix-4 Hamming branch metric stage for the Viterbi decode path. It sits directly downstream of the convolutional encoder's transition table output (expected 6-bit symbol per state/transition). It assembles two received code words into one sliced radix-4 symbol and computes a registered Hamming distance for all 1024 transitions. The result feeds the add-compare-select stage.

---
 rtl/branch_metric_unit_pkg.sv | 28 ++
 rtl/branch_metric_unit_hamming.sv | 22 ++
 rtl/branch_metric_unit.sv | 85 ++++++++
 tb/tb_branch_metric_unit.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_metric_unit_pkg.sv
// Shared constants and types for the radix-4 branch metric stage.
// Holds trellis sizing, metric/symbol typedefs, masks and FSM states.
package param_def;

  localparam int MAX_STATE_NUM    = 256;
  localparam int RADIX            = 4;
  localparam int MAX_CODE_RATE    = 3;
  localparam int SLICED_INPUT_NUM = 6;
  localparam int BM_WIDTH         = 3;
  localparam int STEP_CNT_WIDTH   = 16;

  typedef logic [BM_WIDTH-1:0]         bm_t;
  typedef logic [SLICED_INPUT_NUM-1:0] sym_t;

  typedef sym_t [MAX_STATE_NUM-1:0][RADIX-1:0] trans_arr_t;
  typedef bm_t  [MAX_STATE_NUM-1:0][RADIX-1:0] bm_arr_t;

  // Rate 1/2 drops bit 2 of each word; a half symbol has no upper word.
  localparam sym_t MASK_FULL = 6'b111111;
  localparam sym_t MASK_R12  = 6'b011011;
  localparam sym_t MASK_HALF = 6'b000111;

  typedef enum logic {
    S_FIRST,
    S_SECOND
  } state_t;

endpackage

// File: rtl/branch_metric_unit_hamming.sv
// Masked Hamming distance between received and expected symbol.
// Ports: rx, exp_sym, mask (sym_t) in; bm (bm_t) out.
module bm_hamming
  import param_def::*;
(
  input  sym_t rx,
  input  sym_t exp_sym,
  input  sym_t mask,
  output bm_t  bm
);

  sym_t diff;

  always_comb begin
    diff = (rx ^ exp_sym) & mask;
    bm   = '0;
    for (int k = 0; k < SLICED_INPUT_NUM; k++) begin
      bm = bm + bm_t'(diff[k]);
    end
  end

endmodule

// File: rtl/branch_metric_unit.sv
// Radix-4 Hamming branch metric stage: pairs code words, emits metrics.
// Ports: clk, rst(async low), en_bm, rate, rx word/valid/last, table; bm out.
module branch_metric_unit
  import param_def::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en_bm,
  input  logic                      i_code_rate,
  input  logic [MAX_CODE_RATE-1:0]  i_rx_data,
  input  logic                      i_rx_valid,
  input  logic                      i_rx_last,
  input  trans_arr_t                i_trans_data,
  output bm_arr_t                   o_bm,
  output logic                      o_bm_valid,
  output logic                      o_bm_last,
  output logic [STEP_CNT_WIDTH-1:0] o_step_cnt
);

  state_t                     state;
  logic [MAX_CODE_RATE-1:0]   first_reg;
  logic                       accept;
  logic                       emit;
  sym_t                       sliced;
  sym_t                       mask;
  bm_arr_t                    bm_next;

  assign accept = en_bm & i_rx_valid;
  assign emit   = accept & ((state == S_SECOND) | i_rx_last);

  // In S_FIRST only a half symbol can emit: the word sits in the low half.
  always_comb begin
    sliced = {{MAX_CODE_RATE{1'b0}}, i_rx_data};
    mask   = MASK_FULL;
    if (state == S_SECOND) sliced = {i_rx_data, first_reg};
    if (!i_code_rate)      mask   = mask & MASK_R12;
    if (state == S_FIRST)  mask   = mask & MASK_HALF;
  end

  for (genvar i = 0; i < MAX_STATE_NUM; i++) begin : g_state
    for (genvar j = 0; j < RADIX; j++) begin : g_tr
      bm_hamming u_ham (
        .rx      (sliced),
        .exp_sym (i_trans_data[i][j]),
        .mask    (mask),
        .bm      (bm_next[i][j])
      );
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_FIRST;
      first_reg  <= '0;
      o_bm       <= '0;
      o_bm_valid <= 1'b0;
      o_bm_last  <= 1'b0;
      o_step_cnt <= '0;
    end else if (!en_bm) begin
      state      <= S_FIRST;
      first_reg  <= '0;
      o_bm       <= '0;
      o_bm_valid <= 1'b0;
      o_bm_last  <= 1'b0;
    end else begin
      o_bm_valid <= emit;
      o_bm_last  <= emit & i_rx_last;
      if (emit) begin
        o_bm       <= bm_next;
        o_step_cnt <= o_step_cnt + STEP_CNT_WIDTH'(1);
      end
      if (accept) begin
        unique case (state)
          S_FIRST: begin
            first_reg <= i_rx_data;
            if (!i_rx_last) state <= S_SECOND;
          end
          S_SECOND: state <= S_FIRST;
          default:  state <= S_FIRST;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_metric_unit.sv
// Directed self-checking bench for branch_metric_unit.
// One task per scenario; expected metrics are hand-computed constants.
module tb_branch_metric_unit;
  import param_def::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      en_bm;
  logic                      i_code_rate;
  logic [MAX_CODE_RATE-1:0]  i_rx_data;
  logic                      i_rx_valid;
  logic                      i_rx_last;
  trans_arr_t                i_trans_data;
  bm_arr_t                   o_bm;
  logic                      o_bm_valid;
  logic                      o_bm_last;
  logic [STEP_CNT_WIDTH-1:0] o_step_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  branch_metric_unit dut (
    .clk          (clk),
    .rst          (rst),
    .en_bm        (en_bm),
    .i_code_rate  (i_code_rate),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .i_rx_last    (i_rx_last),
    .i_trans_data (i_trans_data),
    .o_bm         (o_bm),
    .o_bm_valid   (o_bm_valid),
    .o_bm_last    (o_bm_last),
    .o_step_cnt   (o_step_cnt)
  );

  function automatic bm_arr_t fill(input bm_t v);
    bm_arr_t r;
    for (int i = 0; i < MAX_STATE_NUM; i++)
      for (int j = 0; j < RADIX; j++)
        r[i][j] = v;
    return r;
  endfunction

  // Drive one word at negedge; return #1 after the accepting posedge.
  task automatic word(input logic [2:0] d, input logic last);
    @(negedge clk);
    i_rx_data  = d;
    i_rx_valid = 1'b1;
    i_rx_last  = last;
    @(posedge clk);
    #1;
    i_rx_valid = 1'b0;
    i_rx_last  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (o_bm_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_valid got %b want 0", o_bm_valid);
    end
    n_chk++;
    if (o_bm_last !== 1'b0) begin
      n_fail++; $display("FAIL rst_last got %b want 0", o_bm_last);
    end
    n_chk++;
    if (o_step_cnt !== 16'd0) begin
      n_fail++; $display("FAIL rst_cnt got %0d want 0", o_step_cnt);
    end
    n_chk++;
    if (o_bm !== fill(3'd0)) begin
      n_fail++; $display("FAIL rst_bm got [0][0]=%0d want all 0", o_bm[0][0]);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_rate13;
    i_code_rate  = 1'b1;
    i_trans_data = '0;
    word(3'b101, 1'b0);
    n_chk++;
    if (o_bm_valid !== 1'b0) begin
      n_fail++; $display("FAIL r13_first_valid got %b want 0", o_bm_valid);
    end
    word(3'b011, 1'b0);
    exp_cnt++;
    n_chk++;
    if (o_bm_valid !== 1'b1) begin
      n_fail++; $display("FAIL r13_valid got %b want 1", o_bm_valid);
    end
    n_chk++;
    if (o_bm !== fill(3'd4)) begin
      n_fail++; $display("FAIL r13_bm got [0][0]=%0d want all 4", o_bm[0][0]);
    end
    n_chk++;
    if (o_step_cnt !== 16'(exp_cnt)) begin
      n_fail++; $display("FAIL r13_cnt got %0d want %0d", o_step_cnt, exp_cnt);
    end
    n_chk++;
    if (o_bm_last !== 1'b0) begin
      n_fail++; $display("FAIL r13_last got %b want 0", o_bm_last);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (o_bm_valid !== 1'b0) begin
      n_fail++; $display("FAIL r13_pulse_len got %b want 0", o_bm_valid);
    end
    n_chk++;
    if (o_bm !== fill(3'd4)) begin
      n_fail++; $display("FAIL r13_hold got [0][0]=%0d want all 4", o_bm[0][0]);
    end
  endtask

  task automatic test_rate12;
    bm_arr_t e;
    i_code_rate        = 1'b0;
    i_trans_data       = '0;
    i_trans_data[5][2] = 6'b011011;
    e                  = fill(3'd4);
    e[5][2]            = 3'd0;
    word(3'b111, 1'b0);
    word(3'b111, 1'b0);
    exp_cnt++;
    n_chk++;
    if (o_bm_valid !== 1'b1) begin
      n_fail++; $display("FAIL r12_valid got %b want 1", o_bm_valid);
    end
    n_chk++;
    if (o_bm !== e) begin
      n_fail++;
      $display("FAIL r12_bm got [0][0]=%0d [5][2]=%0d want 4 and 0",
               o_bm[0][0], o_bm[5][2]);
    end
    n_chk++;
    if (o_step_cnt !== 16'(exp_cnt)) begin
      n_fail++; $display("FAIL r12_cnt got %0d want %0d", o_step_cnt, exp_cnt);
    end
  endtask

  task automatic test_abort;
    i_code_rate  = 1'b1;
    i_trans_data = '0;
    word(3'b111, 1'b0);
    @(negedge clk);
    en_bm = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if (o_bm !== fill(3'd0)) begin
      n_fail++; $display("FAIL abort_clear got [0][0]=%0d want 0", o_bm[0][0]);
    end
    n_chk++;
    if (o_step_cnt !== 16'(exp_cnt)) begin
      n_fail++; $display("FAIL abort_cnt got %0d want %0d", o_step_cnt, exp_cnt);
    end
    @(negedge clk);
    en_bm = 1'b1;
    word(3'b000, 1'b0);
    n_chk++;
    if (o_bm_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_stale got %b want 0", o_bm_valid);
    end
    word(3'b000, 1'b0);
    exp_cnt++;
    n_chk++;
    if (o_bm_valid !== 1'b1 || o_bm !== fill(3'd0)) begin
      n_fail++;
      $display("FAIL abort_pulse got v=%b bm=%0d want v=1 bm=0",
               o_bm_valid, o_bm[0][0]);
    end
    // Completing word on the same edge that en_bm falls.
    word(3'b111, 1'b0);
    @(negedge clk);
    i_rx_data  = 3'b111;
    i_rx_valid = 1'b1;
    en_bm      = 1'b0;
    @(posedge clk);
    #1;
    i_rx_valid = 1'b0;
    n_chk++;
    if (o_bm_valid !== 1'b0 || o_step_cnt !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL abort_same_edge got v=%b cnt=%0d want v=0 cnt=%0d",
               o_bm_valid, o_step_cnt, exp_cnt);
    end
    @(negedge clk);
    en_bm = 1'b1;
  endtask

  task automatic test_half;
    i_code_rate  = 1'b1;
    i_trans_data = '0;
    word(3'b111, 1'b1);
    exp_cnt++;
    n_chk++;
    if (o_bm_valid !== 1'b1 || o_bm_last !== 1'b1) begin
      n_fail++;
      $display("FAIL half_flags got v=%b l=%b want 1 1", o_bm_valid, o_bm_last);
    end
    n_chk++;
    if (o_bm !== fill(3'd3)) begin
      n_fail++; $display("FAIL half_bm got [0][0]=%0d want all 3", o_bm[0][0]);
    end
    word(3'b000, 1'b0);
    n_chk++;
    if (o_bm_valid !== 1'b0) begin
      n_fail++; $display("FAIL half_state got %b want 0", o_bm_valid);
    end
    word(3'b000, 1'b1);
    exp_cnt++;
    n_chk++;
    if (o_bm_valid !== 1'b1 || o_bm_last !== 1'b1 || o_bm !== fill(3'd0)) begin
      n_fail++;
      $display("FAIL half_full_last got v=%b l=%b bm=%0d want 1 1 0",
               o_bm_valid, o_bm_last, o_bm[0][0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] got;
    i_code_rate  = 1'b1;
    i_trans_data = '0;
    @(negedge clk);
    i_rx_valid = 1'b1;
    i_rx_last  = 1'b0;
    i_rx_data  = 3'b001;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      got[k] = o_bm_valid;
    end
    i_rx_valid = 1'b0;
    exp_cnt += 2;
    n_chk++;
    if (got !== 4'b1010) begin
      n_fail++; $display("FAIL b2b_pattern got %b want 1010", got);
    end
    n_chk++;
    if (o_step_cnt !== 16'(exp_cnt) || o_bm !== fill(3'd2)) begin
      n_fail++;
      $display("FAIL b2b_result got cnt=%0d bm=%0d want cnt=%0d bm=2",
               o_step_cnt, o_bm[0][0], exp_cnt);
    end
  endtask

  task automatic test_reset_mid;
    i_code_rate  = 1'b1;
    i_trans_data = '0;
    word(3'b111, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    n_chk++;
    if (o_bm !== fill(3'd0) || o_step_cnt !== 16'd0 || o_bm_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_async got bm=%0d cnt=%0d v=%b want 0 0 0",
               o_bm[0][0], o_step_cnt, o_bm_valid);
    end
    @(negedge clk);
    rst     = 1'b1;
    exp_cnt = 0;
    word(3'b101, 1'b0);
    n_chk++;
    if (o_bm_valid !== 1'b0) begin
      n_fail++; $display("FAIL rmid_no_pulse got %b want 0", o_bm_valid);
    end
    word(3'b011, 1'b0);
    exp_cnt++;
    n_chk++;
    if (o_bm_valid !== 1'b1 || o_bm !== fill(3'd4) || o_step_cnt !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL rmid_pulse got v=%b bm=%0d cnt=%0d want 1 4 %0d",
               o_bm_valid, o_bm[0][0], o_step_cnt, exp_cnt);
    end
  endtask

  task automatic test_wrap;
    i_code_rate  = 1'b1;
    i_trans_data = '0;
    @(negedge clk);
    i_rx_data  = 3'b111;
    i_rx_valid = 1'b1;
    i_rx_last  = 1'b1;
    repeat (65535 - exp_cnt) @(posedge clk);
    #1;
    n_chk++;
    if (o_step_cnt !== 16'hFFFF) begin
      n_fail++; $display("FAIL wrap_max got %h want ffff", o_step_cnt);
    end
    @(posedge clk);
    #1;
    i_rx_valid = 1'b0;
    i_rx_last  = 1'b0;
    n_chk++;
    if (o_step_cnt !== 16'd0 || o_bm_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_zero got cnt=%h v=%b want 0000 1",
               o_step_cnt, o_bm_valid);
    end
  endtask

  initial begin
    rst          = 1'b0;
    en_bm        = 1'b1;
    i_code_rate  = 1'b1;
    i_rx_data    = '0;
    i_rx_valid   = 1'b0;
    i_rx_last    = 1'b0;
    i_trans_data = '0;
    test_reset;
    test_rate13;
    test_rate12;
    test_abort;
    test_half;
    test_back_to_back;
    test_reset_mid;
    test_wrap;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
